traffic_light: RTL and testbench

- Single-intersection traffic light controller. A Moore FSM cycles RED -> GREEN -> YELLOW -> RED.
- Each phase lasts a parameterised number of clock cycles, timed by one shared down-free up-counter.
- Drives a 3-bit one-hot lamp vector (R-Y-G) to the pad/lamp driver layer. Top-level leaf block, no handshakes.

---
 rtl/traffic_light_pkg.sv | 19 +
 rtl/traffic_light.sv | 68 ++++++
 tb/tb_traffic_light.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared state encoding, lamp codes and default phase durations
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    GREEN  = 2'b01,
    YELLOW = 2'b10
  } light_state_t;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int unsigned DEF_RED_CYCLES    = 5_000_000;
  localparam int unsigned DEF_GREEN_CYCLES  = 5_000_000;
  localparam int unsigned DEF_YELLOW_CYCLES = 2_000_000;
  localparam int unsigned DEF_CNT_W         = 32;

endpackage

// File: rtl/traffic_light.sv
// rtl/traffic_light.sv - single-intersection RED/GREEN/YELLOW Moore controller
// One shared up-counter times every phase; lamps decode from state alone.
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int unsigned RED_CYCLES    = DEF_RED_CYCLES,
  parameter int unsigned GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int unsigned YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] lights
);

  light_state_t     state;
  light_state_t     w_state_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] w_counter_nxt;
  logic [CNT_W-1:0] w_dur_m1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RED;
      counter <= '0;
    end else begin
      state   <= w_state_nxt;
      counter <= w_counter_nxt;
    end
  end

  // The illegal encoding jumps straight back to RED with a fresh count.
  always_comb begin
    w_dur_m1      = '0;
    w_state_nxt   = RED;
    w_counter_nxt = '0;
    lights        = LAMP_RED;
    case (state)
      RED: begin
        w_dur_m1    = CNT_W'(RED_CYCLES - 1);
        w_state_nxt = GREEN;
        lights      = LAMP_RED;
      end
      GREEN: begin
        w_dur_m1    = CNT_W'(GREEN_CYCLES - 1);
        w_state_nxt = YELLOW;
        lights      = LAMP_GREEN;
      end
      YELLOW: begin
        w_dur_m1    = CNT_W'(YELLOW_CYCLES - 1);
        w_state_nxt = RED;
        lights      = LAMP_YELLOW;
      end
      default: begin
        w_dur_m1    = '0;
        w_state_nxt = RED;
        lights      = LAMP_RED;
      end
    endcase
    if ((state == RED) || (state == GREEN) || (state == YELLOW)) begin
      if (counter != w_dur_m1) begin
        w_state_nxt   = state;
        w_counter_nxt = counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_light.sv
// tb/tb_traffic_light.sv - randomized-reset bench against a time-since-release reference model
module tb_traffic_light;
  import traffic_light_pkg::*;

  logic       clk = 1'b0;
  logic       rst_d = 1'b1;
  logic       rst_s = 1'b1;
  logic       rst_m = 1'b1;
  logic [2:0] lights_d;
  logic [2:0] lights_s;
  logic [2:0] lights_m;

  int n_vec = 0;
  int n_err = 0;
  int k_d = 0;
  int k_s = 0;
  int k_m = 0;

  always #5 clk = ~clk;

  traffic_light dut_d (.clk(clk), .reset(rst_d), .lights(lights_d));

  traffic_light #(.RED_CYCLES(5), .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .CNT_W(8))
    dut_s (.clk(clk), .reset(rst_s), .lights(lights_s));

  traffic_light #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1), .CNT_W(4))
    dut_m (.clk(clk), .reset(rst_m), .lights(lights_m));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Position within the period since release fully determines phase and count.
  function automatic void ref_model(input int k, input int r, input int g, input int y,
                                    output int st, output int cnt, output logic [2:0] lamp);
    int p;
    p = k % (r + g + y);
    if (p < r) begin
      st = 0; cnt = p; lamp = 3'b100;
    end else if (p < r + g) begin
      st = 1; cnt = p - r; lamp = 3'b001;
    end else begin
      st = 2; cnt = p - r - g; lamp = 3'b010;
    end
  endfunction

  task automatic check_dut(input string name, input int k, input int r, input int g, input int y,
                           input logic [2:0] obs_l, input logic [1:0] obs_st, input logic [31:0] obs_c);
    int          st;
    int          cnt;
    logic [2:0]  lamp;
    ref_model(k, r, g, y, st, cnt, lamp);
    check_eq({name, ".lights"}, 32'(obs_l), 32'(lamp));
    check_eq({name, ".state"}, 32'(obs_st), 32'(st));
    check_eq({name, ".counter"}, obs_c, 32'(cnt));
    check_eq({name, ".onehot"}, 32'($onehot(obs_l)), 32'd1);
  endtask

  task automatic check_all();
    check_dut("dflt", k_d, 5_000_000, 5_000_000, 2_000_000, lights_d, dut_d.state, 32'(dut_d.counter));
    check_dut("short", k_s, 5, 4, 2, lights_s, dut_s.state, 32'(dut_s.counter));
    check_dut("min", k_m, 1, 1, 1, lights_m, dut_m.state, 32'(dut_m.counter));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_d) k_d++;
    if (rst_s) k_s++;
    if (rst_m) k_m++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bit found;

    rst_d = 1'b0;
    rst_s = 1'b0;
    rst_m = 1'b0;
    #1;
    check_all();
    tick();
    tick();

    rst_d = 1'b1;
    rst_s = 1'b1;
    rst_m = 1'b1;
    for (int i = 0; i < 25; i++) tick();

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (dut_s.state == GREEN && dut_s.counter == 8'd2) found = 1'b1;
    end
    if (!found) check_eq("midphase_timeout", 32'd0, 32'd1);
    rst_s = 1'b0;
    #1;
    k_s = 0;
    check_eq("midphase.async_lights", 32'(lights_s), 32'b100);
    check_eq("midphase.async_counter", 32'(dut_s.counter), 32'd0);
    tick();
    rst_s = 1'b1;
    for (int i = 0; i < 14; i++) tick();

    for (int i = 0; i < 400; i++) begin
      tick();
      if (rst_s) begin
        if ($urandom_range(0, 15) == 0) rst_s = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        rst_s = 1'b1;
      end
      if (rst_m) begin
        if ($urandom_range(0, 15) == 0) rst_m = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        rst_m = 1'b1;
      end
      #1;
      if (!rst_s) begin
        k_s = 0;
        check_eq("rand.async_lights_s", 32'(lights_s), 32'b100);
      end
      if (!rst_m) begin
        k_m = 0;
        check_eq("rand.async_lights_m", 32'(lights_m), 32'b100);
      end
    end

    rst_s = 1'b1;
    rst_m = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    force dut_s.state = light_state_t'(2'b11);
    #1;
    check_eq("illegal.lights", 32'(lights_s), 32'b100);
    check_eq("illegal.onehot", 32'($onehot(lights_s)), 32'd1);
    release dut_s.state;
    @(posedge clk);
    k_d++;
    k_m++;
    k_s = 0;
    @(negedge clk);
    check_all();
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
